// File: rtl/out_port_arbiter_if.sv
// Output-port arbiter bus: request/last/ready from the input side,
// grant/select/pop/valid/watchdog status from the arbiter.
interface out_port_arbiter_if #(
    parameter int PORTS_NUM = 4
) ();
    localparam int N     = PORTS_NUM + 1;
    localparam int SEL_W = $clog2(PORTS_NUM + 1);

    logic [N-1:0]     req_i;
    logic [N-1:0]     last_i;
    logic             dst_ready_i;
    logic [N-1:0]     grant_o;
    logic [SEL_W-1:0] sel_o;
    logic             busy_o;
    logic [N-1:0]     pop_o;
    logic             valid_o;
    logic             wdt_err_o;

    // Arbiter side
    modport slave (
        input  req_i,
        input  last_i,
        input  dst_ready_i,
        output grant_o,
        output sel_o,
        output busy_o,
        output pop_o,
        output valid_o,
        output wdt_err_o
    );

    // Input-buffer / switch side
    modport master (
        output req_i,
        output last_i,
        output dst_ready_i,
        input  grant_o,
        input  sel_o,
        input  busy_o,
        input  pop_o,
        input  valid_o,
        input  wdt_err_o
    );
endinterface

// File: rtl/out_port_arbiter.sv
// Per-output-port wormhole arbiter. Round-robin grant among PORTS_NUM mesh
// inputs plus the local input (index PORTS_NUM); the grant is locked for a
// whole packet and released after the flit marked last is transferred.
// Optional stall watchdog enabled by defining OUT_ARB_WDT_EN: a stalled owner
// is forcibly released after WDT_CYCLES consecutive no-transfer cycles.
module out_port_arbiter #(
    parameter int PORTS_NUM  = 4,
    parameter int WDT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              a_rst,
    out_port_arbiter_if.slave bus
);
    localparam int N     = PORTS_NUM + 1;
    localparam int SEL_W = $clog2(PORTS_NUM + 1);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Configuration sanity checks at elaboration
    if (PORTS_NUM < 1) begin : g_bad_ports
        $error("out_port_arbiter: PORTS_NUM must be at least 1");
    end
    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("out_port_arbiter: WDT_CYCLES must be at least 1");
    end

    state_t           r_state;
    logic [N-1:0]     r_grant;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic             r_busy;

    logic             w_any_req;
    logic [SEL_W-1:0] w_pick;
    logic             w_owner_req;
    logic             w_owner_last;
    logic             w_xfer;
    logic [N-1:0]     w_pop;
    logic [SEL_W-1:0] w_ptr_next;
    logic             w_release;
    logic             w_wdt_fire;

    // First requester found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0]     req,
                                                 input logic [SEL_W-1:0] ptr);
        int   idx;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            idx = int'(ptr) + j;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[SEL_W'(idx)]) begin
                rr_pick = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign w_any_req    = |bus.req_i;
    assign w_pick       = rr_pick(bus.req_i, r_ptr);
    assign w_owner_req  = bus.req_i[r_sel];
    assign w_owner_last = bus.last_i[r_sel];

    // A transfer needs an owner with a flit and a ready downstream; nothing
    // may be popped while reset is asserted, even between clock edges.
    assign w_xfer = (r_state == ST_BUSY) & w_owner_req & bus.dst_ready_i & ~a_rst;
    assign w_pop  = w_xfer ? r_grant : '0;

    // Pointer moves to the input just after the releasing owner.
    assign w_ptr_next = (r_sel == SEL_W'(N - 1)) ? '0 : r_sel + 1'b1;
    assign w_release  = (w_xfer & w_owner_last) | w_wdt_fire;

`ifdef OUT_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt_err;

    // Fires on the edge that completes WDT_CYCLES consecutive stalled cycles.
    assign w_wdt_fire = (r_state == ST_BUSY) & ~w_xfer & (r_wdt_cnt == WDT_LAST);

    // Stall counter: cleared outside BUSY, on every transfer and on firing.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            r_wdt_err <= w_wdt_fire;
            if ((r_state != ST_BUSY) || w_xfer || w_wdt_fire) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
        end
    end

    assign bus.wdt_err_o = r_wdt_err;
`else
    assign w_wdt_fire    = 1'b0;
    assign bus.wdt_err_o = 1'b0;
`endif

    // Grant FSM: arbitrate in IDLE, hold the owner in BUSY until release.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_BUSY;
                        r_grant <= ONE_HOT0 << w_pick;
                        r_sel   <= w_pick;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_o = r_grant;
    assign bus.sel_o   = r_sel;
    assign bus.busy_o  = r_busy;
    assign bus.pop_o   = w_pop;
    assign bus.valid_o = |w_pop;
endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a packet-level reference model.
// Define OUT_ARB_WDT_EN for both bench and design to cover the watchdog.
module tb_out_port_arbiter;
    localparam int PN  = 4;
    localparam int N   = PN + 1;
    localparam int WDT = 8;

    logic clk   = 1'b0;
    logic a_rst = 1'b1;

    out_port_arbiter_if #(.PORTS_NUM(PN)) bus ();

    out_port_arbiter #(
        .PORTS_NUM  (PN),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port, where the scan starts, stall age.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;
    bit m_err   = 1'b0;
    int grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requesters listed in priority order starting at ptr; first one wins.
    function automatic int first_from_ptr(input logic [N-1:0] req, input int ptr);
        int order[$];
        for (int j = 0; j < N; j++) order.push_back((ptr + j) % N);
        foreach (order[j]) begin
            if (((req >> order[j]) & 1) != 0) return order[j];
        end
        return -1;
    endfunction

    task automatic check_regs();
        check_eq("grant", 32'(bus.grant_o), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_eq("busy", 32'(bus.busy_o), (m_owner >= 0) ? 32'd1 : 32'd0);
        if (m_owner >= 0) check_eq("sel", 32'(bus.sel_o), 32'(m_owner));
        check_eq("wdt_err", 32'(bus.wdt_err_o), 32'(m_err));
    endtask

    // One clock cycle: apply inputs, check combinational pop, advance model,
    // then check registered outputs after the edge.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] last, input logic rdy);
        bit xfer;
        bus.req_i       = req;
        bus.last_i      = last;
        bus.dst_ready_i = rdy;
        #1;
        xfer = (m_owner >= 0) && (((req >> m_owner) & 1) != 0) && rdy;
        check_eq("pop", 32'(bus.pop_o), xfer ? (32'd1 << m_owner) : 32'd0);
        check_eq("valid", 32'(bus.valid_o), 32'(xfer));
        m_err = 1'b0;
        if (m_owner < 0) begin
            m_owner = first_from_ptr(req, m_ptr);
            m_stall = 0;
        end else if (xfer) begin
            m_stall = 0;
            if (((last >> m_owner) & 1) != 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
`ifdef OUT_ARB_WDT_EN
            m_stall++;
            if (m_stall == WDT) begin
                m_err   = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
`endif
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic check_all_reset(input string tag);
        check_eq({tag, "_grant"}, 32'(bus.grant_o), 32'd0);
        check_eq({tag, "_sel"}, 32'(bus.sel_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_eq({tag, "_pop"}, 32'(bus.pop_o), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        check_eq({tag, "_wdt"}, 32'(bus.wdt_err_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] r_req;
        logic [N-1:0] r_last;
        bus.req_i       = '1;
        bus.last_i      = '0;
        bus.dst_ready_i = 1'b1;

        // Reset held with requests present: nothing granted or popped
        a_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_reset("rst");
        bus.req_i = '0;
        #3 a_rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle with no requests
        repeat (10) begin
            step('0, '0, 1'b1);
            check_eq("idle_sel", 32'(bus.sel_o), 32'd0);
        end

        // Three-flit packet from input 2
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00100, 1'b1);

        // All inputs requesting single-flit packets: rotation starts at 3
        grant_log.delete();
        repeat (20) begin
            step(5'b11111, 5'b11111, 1'b1);
            if (bus.busy_o) grant_log.push_back(int'(bus.sel_o));
        end
        check_eq("order_n", 32'(grant_log.size()), 32'd10);
        foreach (grant_log[i]) check_eq("order", 32'(grant_log[i]), 32'((3 + i) % N));

        // Owner 1 stalls on ready, then on its own empty buffer
        step(5'b00010, 5'b00000, 1'b1);
        step(5'b00010, 5'b00000, 1'b1);
        repeat (4) step(5'b00011, 5'b00000, 1'b0);
        repeat (3) step(5'b00001, 5'b00000, 1'b1);
        step(5'b00011, 5'b00010, 1'b1);
        step(5'b00011, 5'b00000, 1'b1);
        check_eq("p0_after_p1", 32'(bus.grant_o), 32'd1);
        step(5'b00001, 5'b00001, 1'b1);

        // Asynchronous reset in the middle of a packet from input 3
        step(5'b01000, 5'b00000, 1'b1);
        step(5'b01000, 5'b00000, 1'b1);
        #2 a_rst = 1'b1;
        #1;
        check_all_reset("arst");
        bus.req_i = '0;
        @(posedge clk);
        #2 a_rst = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_stall = 0;
        m_err   = 1'b0;
        @(posedge clk);
        #1;
        check_regs();
        step(5'b11111, 5'b00000, 1'b1);
        check_eq("ptr_after_rst", 32'(bus.grant_o), 32'd1);
        step(5'b11111, 5'b00001, 1'b1);

        // Long downstream stall: watchdog release, or indefinite hold
        step(5'b00110, 5'b00000, 1'b1);
        repeat (12) step(5'b00110, 5'b00000, 1'b0);
        repeat (6) step(5'b00110, 5'b00110, 1'b1);

        // Random traffic
        repeat (600) begin
            r_req  = N'($urandom);
            r_last = N'($urandom & $urandom);
            step(r_req, r_last, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
